// File: rtl/clock_monitor.sv
// Measures the rising-edge period of a slow, asynchronous signal in the clk domain
// and reports lock, period faults and stuck-input timeouts to the control logic.
module clock_monitor #(
    parameter int EXP_PERIOD  = 4,
    parameter int TOL         = 0,
    parameter int LOCK_COUNT  = 4,
    parameter int FAIL_COUNT  = 2,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mon_in,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic             stuck,
    output logic [7:0]       error_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACQUIRE = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_LOCKED  = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(FAIL_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] PER_LO      = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] PER_HI      = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             state_q, state_d;
    logic [GW-1:0]          good_cnt_q, good_cnt_d;
    logic [BW-1:0]          bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   pv_q, pv_d;
    logic                   timeout_q, timeout_d;
    logic                   stuck_q, stuck_d;
    logic [7:0]             err_q, err_d;

    logic edge_det;
    logic measuring;
    logic period_good;
    logic good_ev;
    logic bad_ev;
    logic restart;

    // sync_q[0] is the newest sample; the edge is taken between the last two stages
    assign edge_det    = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign measuring   = state_q inside {S_MEASURE, S_LOCKED, S_FAULT};
    assign period_good = (period_q >= PER_LO) && (period_q <= PER_HI);
    assign good_ev     = pv_q && period_good;
    assign bad_ev      = pv_q && !period_good;

    // State decisions act on the registered period, so locked/fault trail period_valid by one cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        restart    = 1'b0;
        if (!enable) begin
            state_d    = S_IDLE;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ACQUIRE;
                S_ACQUIRE: begin
                    if (timeout_q) begin
                        state_d = S_FAULT;
                    end else if (edge_det) begin
                        state_d    = S_MEASURE;
                        good_cnt_d = '0;
                    end
                end
                S_MEASURE: begin
                    if (timeout_q) begin
                        state_d = S_FAULT;
                    end else if (good_ev) begin
                        if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                            state_d   = S_LOCKED;
                            bad_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end else if (bad_ev) begin
                        good_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (timeout_q) begin
                        state_d = S_FAULT;
                    end else if (good_ev) begin
                        bad_cnt_d = '0;
                    end else if (bad_ev) begin
                        if (bad_cnt_q == BW'(FAIL_COUNT - 1)) begin
                            state_d = S_FAULT;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 1'b1;
                        end
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
            // A clear beats any event that would otherwise land (or keep) us in FAULT.
            if (clr_fault && (state_q == S_FAULT || state_d == S_FAULT)) begin
                state_d = S_ACQUIRE;
                restart = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        pv_d      = 1'b0;
        timeout_d = 1'b0;
        stuck_d   = stuck_q;
        err_d     = err_q;
        if (!enable) begin
            cnt_d    = '0;
            period_d = '0;
            stuck_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            // The cycle leaving IDLE is the timeout reference for ACQUIRE.
            cnt_d   = CNT_W'(1);
            stuck_d = 1'b0;
        end else begin
            pv_d      = edge_det && measuring;
            timeout_d = !edge_det && !restart && (cnt_q == TIMEOUT_CNT);
            if (pv_d) begin
                period_d = cnt_q;
            end
            if (restart || edge_det) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (clr_fault || edge_det) begin
                stuck_d = 1'b0;
            end else if (timeout_d) begin
                stuck_d = 1'b1;
            end
            if ((bad_ev || timeout_q) && err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
        if (reset) begin
            sync_q     <= '0;
            state_q    <= S_IDLE;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            cnt_q      <= '0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            timeout_q  <= 1'b0;
            stuck_q    <= 1'b0;
            err_q      <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], mon_in};
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            pv_q       <= pv_d;
            timeout_q  <= timeout_d;
            stuck_q    <= stuck_d;
            err_q      <= err_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = pv_q;
    assign locked       = (state_q == S_LOCKED);
    assign fault        = (state_q == S_FAULT);
    assign stuck        = stuck_q;
    assign error_count  = err_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: stimulus queues the expected period and the
// status that must follow each period_valid; a monitor process pops and compares.
module tb_clock_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             mon_in;
    logic             clr_fault;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             locked;
    logic             fault;
    logic             stuck;
    logic [7:0]       error_count;

    typedef struct {
        int period;
        bit lk;
        bit flt;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cyc         = 0;
    int   last_pv_cyc = 0;

    clock_monitor #(
        .EXP_PERIOD (4),
        .TOL        (0),
        .LOCK_COUNT (4),
        .FAIL_COUNT (2),
        .TIMEOUT    (16),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mon_in      (mon_in),
        .clr_fault   (clr_fault),
        .period_out  (period_out),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault),
        .stuck       (stuck),
        .error_count (error_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising edge on mon_in now, next rising edge `hold` cycles later (high for two cycles).
    // If pv is set, the period this edge closes and the status one cycle after its
    // period_valid are queued. clr_on_pv raises clr_fault in that period_valid cycle.
    task automatic mon_edge(input int hold, input bit pv, input int per, input bit lk,
                            input bit flt, input int err, input bit clr_on_pv);
        exp_t e;
        bit   done;
        done = 1'b0;
        if (pv) begin
            e.period = per;
            e.lk     = lk;
            e.flt    = flt;
            e.err    = err;
            exp_q.push_back(e);
        end
        mon_in = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (clr_on_pv && !done && period_valid) begin
                clr_fault = 1'b1;
                done      = 1'b1;
            end
            @(posedge clk);
            #1;
            clr_fault = 1'b0;
            if (i == 1) mon_in = 1'b0;
        end
        if (clr_on_pv) check("clr_aligned_with_period_valid", int'(done), 1);
    endtask

    task automatic wait_stuck(input int budget, output int at_cyc);
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (stuck) begin
                at_cyc = cyc;
                break;
            end
        end
        check("stuck_within_budget", int'(at_cyc >= 0), 1);
    endtask

    task automatic check_cleared(input string tag, input int exp_err);
        check({tag, "_period_out"}, int'(period_out), 0);
        check({tag, "_period_valid"}, int'(period_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_fault"}, int'(fault), 0);
        check({tag, "_stuck"}, int'(stuck), 0);
        check({tag, "_error_count"}, int'(error_count), exp_err);
    endtask

    // Monitor: every period_valid must match the head of the queue, and the
    // status one cycle later must match what was queued with it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && period_valid) begin
                last_pv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("queued_expectation_present", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("period_out", int'(period_out), e.period);
                    @(negedge clk);
                    check("locked_after_period", int'(locked), int'(e.lk));
                    check("fault_after_period", int'(fault), int'(e.flt));
                    check("error_count_after_period", int'(error_count), e.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_stuck;
        int t_ref;
        reset     = 1'b1;
        enable    = 1'b0;
        mon_in    = 1'b0;
        clr_fault = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_cleared("reset", 0);
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();

        // Steady 4-cycle input: reference edge, then lock on the 4th good period.
        mon_edge(4, 0, 0, 0, 0, 0, 0);
        mon_edge(4, 1, 4, 0, 0, 0, 0);
        mon_edge(4, 1, 4, 0, 0, 0, 0);
        mon_edge(4, 1, 4, 0, 0, 0, 0);
        mon_edge(4, 1, 4, 1, 0, 0, 0);

        // One period of 5 while locked: counted, lock kept, bad count recovers.
        mon_edge(5, 1, 4, 1, 0, 0, 0);
        mon_edge(4, 1, 5, 1, 0, 1, 0);
        mon_edge(6, 1, 4, 1, 0, 1, 0);

        // Period moves to 6: second consecutive bad period faults.
        mon_edge(6, 1, 6, 1, 0, 2, 0);
        mon_edge(6, 1, 6, 0, 1, 3, 0);
        mon_edge(6, 1, 6, 0, 1, 4, 0);
        // clr_fault coincident with a bad period: clear wins, event still counted.
        mon_edge(4, 1, 6, 0, 0, 5, 1);

        // Back in ACQUIRE: reference edge plus four good periods relocks.
        mon_edge(4, 0, 0, 0, 0, 5, 0);
        mon_edge(4, 1, 4, 0, 0, 5, 0);
        mon_edge(4, 1, 4, 0, 0, 5, 0);
        mon_edge(4, 1, 4, 0, 0, 5, 0);
        mon_edge(4, 1, 4, 1, 0, 5, 0);

        // mon_in held low while locked.
        wait_stuck(40, t_stuck);
        check("stuck_delay_after_last_period", t_stuck - last_pv_cyc, 16);
        check("fault_lags_stuck", int'(fault), 0);
        check("locked_until_timeout_acted", int'(locked), 1);
        @(negedge clk);
        check("fault_after_timeout", int'(fault), 1);
        check("locked_after_timeout", int'(locked), 0);
        check("error_count_after_timeout", int'(error_count), 6);
        repeat (24) @(negedge clk);
        check("timeout_counted_once", int'(error_count), 6);
        check("stuck_held", int'(stuck), 1);

        // clr_fault with mon_in still low: ACQUIRE, then stuck again.
        tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        @(negedge clk);
        t_ref = cyc;
        check("fault_cleared_by_clr", int'(fault), 0);
        check("stuck_cleared_by_clr", int'(stuck), 0);
        wait_stuck(40, t_stuck);
        check("stuck_delay_after_acquire", t_stuck - t_ref, 16);
        @(negedge clk);
        check("fault_after_acquire_timeout", int'(fault), 1);
        check("error_count_after_second_timeout", int'(error_count), 7);

        // Clear, then restore the 4-cycle input and relock.
        tick();
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        @(negedge clk);
        check("fault_cleared_before_restore", int'(fault), 0);
        tick();
        mon_edge(4, 0, 0, 0, 0, 7, 0);
        mon_edge(4, 1, 4, 0, 0, 7, 0);
        mon_edge(4, 1, 4, 0, 0, 7, 0);
        mon_edge(4, 1, 4, 0, 0, 7, 0);
        mon_edge(16, 1, 4, 1, 0, 7, 0);
        // Edge lands exactly when the count reaches TIMEOUT: bad period, no timeout.
        mon_edge(4, 1, 16, 1, 0, 8, 0);
        mon_edge(4, 1, 4, 1, 0, 8, 0);

        // enable low while locked: IDLE, error_count preserved.
        enable = 1'b0;
        tick();
        @(negedge clk);
        check_cleared("disable", 8);
        tick();
        enable = 1'b1;
        tick();
        mon_edge(4, 0, 0, 0, 0, 8, 0);
        mon_edge(4, 1, 4, 0, 0, 8, 0);
        mon_edge(4, 1, 4, 0, 0, 8, 0);
        mon_edge(4, 1, 4, 0, 0, 8, 0);
        mon_edge(4, 1, 4, 1, 0, 8, 0);

        // reset while locked: everything returns to reset values.
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_cleared("reset_while_locked", 0);
        tick();
        reset = 1'b0;

        repeat (5) @(negedge clk);
        check("expectations_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
